// File: rtl/pri_irq_ctrl_4_if.sv
// Request/presentation bundle between interrupt sources, the controller and its consumer.
interface pri_irq_ctrl_4_if;
    logic [3:0] req;
    logic [3:0] mask;
    logic       ack;
    logic [1:0] out;
    logic       valid;
    logic       ovf;

    modport master (output req, mask, ack, input out, valid, ovf);
    modport slave  (input req, mask, ack, output out, valid, ovf);
endinterface

// File: rtl/pri_irq_ctrl_4.sv
// 4-line fixed-priority interrupt controller: captures request events into pending,
// presents the highest eligible index and holds it until acknowledged.
module pri_irq_ctrl_4 #(
    parameter bit EDGE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    pri_irq_ctrl_4_if.slave  bus
);
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t     state, state_nxt;
    logic [3:0] req_d;
    logic [3:0] pending, pending_nxt;
    logic [3:0] evt, clr, eligible;
    logic [1:0] out_q, out_nxt;
    logic       ovf_q, lost;

    assign evt      = EDGE ? (bus.req & ~req_d) : bus.req;
    assign eligible = pending & ~bus.mask;

    // Only an accepted presentation clears; set wins over clear on the same bit.
    always_comb begin
        clr = 4'b0000;
        if (state == PRESENT && bus.ack)
            clr[out_q] = 1'b1;
    end

    assign pending_nxt = (pending & ~clr) | evt;
    // A held level re-asserts every cycle by design, so loss is only meaningful in edge mode.
    assign lost        = EDGE && ((evt & pending & ~clr) != 4'b0000);

    always_comb begin
        state_nxt = state;
        out_nxt   = out_q;
        case (state)
            IDLE: begin
                if (eligible != 4'b0000) begin
                    state_nxt = PRESENT;
                    for (int i = 0; i < 4; i++)
                        if (eligible[i])
                            out_nxt = 2'(i);
                end
            end
            PRESENT: begin
                if (bus.ack)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            req_d   <= 4'b0000;
            pending <= 4'b0000;
            out_q   <= 2'b00;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            req_d   <= bus.req;
            pending <= pending_nxt;
            out_q   <= out_nxt;
            if (lost)
                ovf_q <= 1'b1;
        end
    end

    assign bus.out   = out_q;
    assign bus.valid = (state == PRESENT);
    assign bus.ovf   = ovf_q;
endmodule
